// File: rtl/reg_file_param.sv
// reg_file_param: parameterised two-read / one-write register file with a
// sequential clear sweep.
//
// Build option: define REG_FILE_BYPASS_EN so that a read of the address being
// written in the same cycle returns the new write data. When it is left
// undefined, that read returns the entry contents from before the write.
//
// State table
//   state    | meaning
//   ST_CLEAR | sweep zeroing one entry per clock; BUSY=1; WEN/REN/CLR ignored
//   ST_READY | normal operation; CLR starts a new sweep, WEN writes, REN reads
//
// Port names follow the existing block interface. Internal registers use an
// r_ prefix, and combinational nets use a w_ prefix.

module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CLR,
    input  logic              WEN,
    input  logic [ADDR_W-1:0] WADR,
    input  logic [DATA_W-1:0] ALUIN,
    input  logic              REN,
    input  logic [ADDR_W-1:0] RADR1,
    input  logic [ADDR_W-1:0] RADR2,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2,
    output logic              OUT_VALID,
    output logic              BUSY
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_out1;
    logic [DATA_W-1:0] r_out2;
    logic              r_valid;
    logic              r_busy;

    logic              w_ready;
    logic              w_do_wr;
    logic              w_do_rd;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // A CLR request takes priority, so any write or read in the same cycle
    // is dropped. Writes to entry 0 are discarded when it is hardwired to zero.
    assign w_ready = (r_state == ST_READY);
    assign w_do_wr = w_ready && !CLR && WEN && !(ZERO_REG && (WADR == '0));
    assign w_do_rd = w_ready && !CLR && REN;

    // Read data for port 1, with the optional write bypass and the zero-entry override.
    always_comb begin
        w_rd1 = r_mem[RADR1];
`ifdef REG_FILE_BYPASS_EN
        if (WEN && (WADR == RADR1)) w_rd1 = ALUIN;
`endif
        if (ZERO_REG && (RADR1 == '0)) w_rd1 = '0;
    end

    // Read data for port 2, built the same way as port 1.
    always_comb begin
        w_rd2 = r_mem[RADR2];
`ifdef REG_FILE_BYPASS_EN
        if (WEN && (WADR == RADR2)) w_rd2 = ALUIN;
`endif
        if (ZERO_REG && (RADR2 == '0)) w_rd2 = '0;
    end

    // Storage array: the clear sweep writes zeros; otherwise accepted writes
    // store their data. There is no reset on this block, because the sweep
    // that follows reset initialises every entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_idx] <= '0;
            end else if (w_do_wr) begin
                r_mem[WADR] <= ALUIN;
            end
        end
    end

    // Control FSM, sweep index, and registered read outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
            r_out1  <= '0;
            r_out2  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_CLEAR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (CLR) begin
                        r_state <= ST_CLEAR;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end else if (w_do_rd) begin
                        r_out1  <= w_rd1;
                        r_out2  <= w_rd2;
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_idx   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign OUT1      = r_out1;
    assign OUT2      = r_out2;
    assign OUT_VALID = r_valid;
    assign BUSY      = r_busy;

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
REQ-001 Parameter DATA_W, default 16, register and data width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 Parameter ZERO_REG, default 0; 1 = entry 0 reads as zero and writes to it are discarded.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 CLR  input  1  request to clear all entries to zero.
REQ-007 WEN  input  1  write enable.
REQ-008 WADR  input  ADDR_W  write address.
REQ-009 ALUIN  input  DATA_W  write data.
REQ-010 REN  input  1  read enable, both ports.
REQ-011 RADR1  input  ADDR_W  read address, port 1.
REQ-012 RADR2  input  ADDR_W  read address, port 2.
REQ-013 OUT1  output  DATA_W  registered read data, port 1.
REQ-014 OUT2  output  DATA_W  registered read data, port 2.
REQ-015 OUT_VALID  output  1  one-cycle pulse: OUT1/OUT2 updated by a read.
REQ-016 BUSY  output  1  high while a clear sweep is running; all requests ignored.

Function
REQ-017 The block SHALL implement a two-state FSM: CLEAR and READY.
REQ-018 In CLEAR, each posedge SHALL write zero to entry IDX and increment IDX; the edge clearing IDX = DEPTH-1 SHALL move the FSM to READY.
REQ-019 In READY, CLR = 1 at a posedge SHALL set IDX = 0 and move to CLEAR; CLR in CLEAR SHALL be ignored (no restart).
REQ-020 BUSY SHALL equal 1 exactly when the FSM is in CLEAR.
REQ-021 In READY, WEN = 1 SHALL write ALUIN to entry WADR at the posedge (except entry 0 when ZERO_REG = 1).
REQ-022 In READY, REN = 1 at a posedge SHALL load OUT1/OUT2 with entries RADR1/RADR2 and assert OUT_VALID for the following cycle; read latency is exactly 1 cycle.
REQ-023 When no read is accepted, OUT1/OUT2 SHALL hold their last values and OUT_VALID SHALL be 0.
REQ-024 In CLEAR, WEN and REN SHALL have no effect; OUT_VALID SHALL be 0.
REQ-025 When ZERO_REG = 1, a read of address 0 SHALL return 0 regardless of bypass.
REQ-026 Simultaneous CLR and WEN/REN in READY: CLR SHALL win; write and read are both dropped.
REQ-027 RADR1 = RADR2 SHALL return identical data on both ports.

Reset
REQ-028 rst = 1 at a posedge SHALL force: FSM = CLEAR, IDX = 0, OUT1 = 0, OUT2 = 0, OUT_VALID = 0, BUSY = 1.
REQ-029 rst during a sweep SHALL restart the sweep at IDX = 0.
REQ-030 BUSY SHALL fall exactly DEPTH posedges after the first posedge with rst = 0; no initial-block contents are relied upon.

Configuration
REQ-031 Macro REG_FILE_BYPASS_EN defined: a read in the same cycle as a write to the same address (WEN = REN = 1, RADR = WADR) SHALL return the new ALUIN on that port.
REQ-032 Macro REG_FILE_BYPASS_EN undefined: such a read SHALL return the entry contents before the write; the write still completes.

Verification
REQ-033 Reset release, defaults: rst 1 cycle then 0 -> BUSY = 1 for 16 cycles, then 0; read of all 16 addresses returns 0x0000.
REQ-034 Write/read: WEN, WADR = 5, ALUIN = 0xBEEF; next cycle REN, RADR1 = 5, RADR2 = 0 -> one cycle later OUT1 = 0xBEEF, OUT2 = 0x0000, OUT_VALID = 1 for one cycle.
REQ-035 Same-cycle collision: entry 3 = 0x1111; WEN, WADR = 3, ALUIN = 0x2222 with REN, RADR1 = 3 -> OUT1 = 0x2222 with REG_FILE_BYPASS_EN, 0x1111 without; following read returns 0x2222.
REQ-036 Clear: fill entries with 0xA5A5; pulse CLR with WEN, WADR = 7, ALUIN = 0x1234 -> BUSY high 16 cycles, REN during sweep gives OUT_VALID = 0, afterwards entry 7 reads 0x0000.
REQ-037 Reset mid-sweep: rst at IDX = 9 -> BUSY stays high 16 more cycles after rst falls; OUT1/OUT2 = 0.
REQ-038 ZERO_REG = 1, DATA_W = 32, ADDR_W = 5: write 0xFFFFFFFF to address 0 and 31 -> address 0 reads 0, address 31 reads 0xFFFFFFFF; BUSY duration 32 cycles.
